// File: rtl/uart_word_tx_pkg.sv
// Shared definitions for the two-byte word transmitter: state encodings and default timing.
// The optional ACK timeout in uart_word_tx is enabled by defining WORD_TX_TIMEOUT_EN.
package uart_word_tx_pkg;

    localparam int DEFAULT_GAP_CYCLES     = 48;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] ST_IDLE    = 4'd0;
    localparam logic [STATE_W-1:0] ST_SEND_HI = 4'd1;
    localparam logic [STATE_W-1:0] ST_ACK_HI  = 4'd2;
    localparam logic [STATE_W-1:0] ST_FREE_HI = 4'd3;
    localparam logic [STATE_W-1:0] ST_GAP     = 4'd4;
    localparam logic [STATE_W-1:0] ST_SEND_LO = 4'd5;
    localparam logic [STATE_W-1:0] ST_ACK_LO  = 4'd6;
    localparam logic [STATE_W-1:0] ST_FREE_LO = 4'd7;
    localparam logic [STATE_W-1:0] ST_DONE    = 4'd8;

    // High byte travels first; the receiver rebuilds the angle from hi[3:0] and lo.
    typedef struct packed {
        logic [7:0] hi;
        logic [7:0] lo;
    } word_bytes_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_word_tx_cycle_counter.sv
// Saturating cycle counter with synchronous clear and terminal-count compare,
// shared by the inter-byte gap and the ACK timeout.
module cycle_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] terminal,
    output logic             at_term
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign at_term = (count_q == terminal);

endmodule

// File: rtl/uart_word_tx.sv
// Sends a 16-bit word as two bytes (high first) through an attached uart_tx, with an idle gap.
// Define WORD_TX_TIMEOUT_EN to abort a byte whose tx_busy never rises within TIMEOUT_CYCLES.
module uart_word_tx
    import uart_word_tx_pkg::*;
#(
    parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        word_in,
    input  logic               word_valid,
    output logic               word_ready,
    output logic               start_tx,
    output logic [7:0]         data_to_tx,
    input  logic               tx_busy,
    output logic               sent,
    output logic               timeout_err,
    output logic               active,
    output logic [STATE_W-1:0] dbg_state
);

    localparam int CNT_W = $clog2(max_int(max_int(GAP_CYCLES, TIMEOUT_CYCLES), 1) + 1);
    localparam logic [CNT_W-1:0] GAP_TERM = CNT_W'(max_int(GAP_CYCLES, 1) - 1);
    localparam logic [CNT_W-1:0] TMO_TERM = CNT_W'(max_int(TIMEOUT_CYCLES, 1) - 1);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    word_bytes_t        word_q;
    word_bytes_t        word_d;
    logic [7:0]         data_q;
    logic [7:0]         data_d;

    logic             accept;
    logic             is_ack;
    logic             ack_timeout;
    logic             cnt_clear;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_term;
    logic             cnt_at_term;

    // Handshake: a word moves when word_valid && word_ready on a rising edge; word_ready
    // is high only in IDLE outside reset, and word_valid is ignored at all other times.
    assign word_ready = (state_q == ST_IDLE) && !reset;
    assign accept     = word_valid && word_ready;
    assign is_ack     = (state_q == ST_ACK_HI) || (state_q == ST_ACK_LO);

`ifdef WORD_TX_TIMEOUT_EN
    assign ack_timeout = is_ack && !tx_busy && cnt_at_term;
`else
    assign ack_timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    word_d  = word_in;
                    data_d  = word_in[15:8];
                    state_d = ST_SEND_HI;
                end
            end
            ST_SEND_HI: state_d = ST_ACK_HI;
            ST_ACK_HI: begin
                if (tx_busy) begin
                    state_d = ST_FREE_HI;
                end else if (ack_timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FREE_HI: begin
                if (!tx_busy) begin
                    if (GAP_CYCLES == 0) begin
                        data_d  = word_q.lo;
                        state_d = ST_SEND_LO;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_at_term) begin
                    data_d  = word_q.lo;
                    state_d = ST_SEND_LO;
                end
            end
            ST_SEND_LO: state_d = ST_ACK_LO;
            ST_ACK_LO: begin
                if (tx_busy) begin
                    state_d = ST_FREE_LO;
                end else if (ack_timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FREE_LO: begin
                if (!tx_busy) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter restarts from zero on every state change, so GAP and ACK each see a fresh count.
    assign cnt_clear = (state_d != state_q);
    assign cnt_en    = (state_q == ST_GAP) || is_ack;
    assign cnt_term  = (state_q == ST_GAP) ? GAP_TERM : TMO_TERM;

    cycle_counter #(
        .WIDTH (CNT_W)
    ) u_cycle_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .enable   (cnt_en),
        .terminal (cnt_term),
        .at_term  (cnt_at_term)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            data_q  <= data_d;
        end
    end

    assign start_tx    = ((state_q == ST_SEND_HI) || (state_q == ST_SEND_LO)) && !reset;
    assign data_to_tx  = data_q;
    assign sent        = (state_q == ST_DONE) && !reset;
    assign timeout_err = ack_timeout && !reset;
    assign active      = (state_q != ST_IDLE);
    assign dbg_state   = state_q;

endmodule
